mmio_irq_sched: RTL and testbench
=================================

MMIO_IRQ_SCHED -- requirements
Module: mmio_irq_sched

Interface
REQ-001 Parameter NUM_SRC, default 8, number of MMIO interrupt sources (2..32) SHALL be supported.
REQ-002 Parameter ACK_BIT, default 0, SHALL select the TIE_EXPSTATE bit used as the core acknowledge toggle.
REQ-003 Parameter HOLDOFF, default 4, SHALL set the deassert-to-next-assert gap in cycles (1..15).
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the ack watchdog limit and SHALL be used only under MMIO_IRQ_TIMEOUT_EN.
REQ-005 CLK  in  1  sole clock; all state SHALL be on its rising edge.
REQ-006 BReset  in  1  reset, asynchronous assert, active-high.
REQ-007 src_irq  in  NUM_SRC  level interrupt sources; a rising edge SHALL request service.
REQ-008 cfg_we  in  1  mask write strobe.
REQ-009 cfg_wdata  in  NUM_SRC  new mask value (1 = enabled).
REQ-010 TIE_EXPSTATE  in  32  core export state; bit ACK_BIT SHALL carry the acknowledge toggle.
REQ-011 BInterrupt06  out  1  level interrupt to core.
REQ-012 irq_id  out  5  index of the source being serviced, valid while BInterrupt06=1.
REQ-013 pending  out  NUM_SRC  pending register.
REQ-014 mask  out  NUM_SRC  current mask register.
REQ-015 timeout_flag  out  1  sticky watchdog flag.

Function
REQ-016 Edge detect: src_q SHALL register src_irq; rise[i] = src_irq[i] & ~src_q[i]; pending[i] SHALL set on the following edge, independent of mask.
REQ-017 FSM states IDLE, ASSERT, HOLD SHALL exist; IDLE->ASSERT when |(pending & mask); ASSERT->HOLD on ack (or timeout); HOLD->IDLE after HOLDOFF cycles.
REQ-018 On IDLE->ASSERT, winner SHALL be chosen round-robin from pending & mask starting at rr_ptr; irq_id SHALL latch the winner; BInterrupt06 SHALL be registered high the next cycle.
REQ-019 Latency: rise at edge N -> pending at N+1 -> BInterrupt06 high at N+2 when IDLE and mask bit set.
REQ-020 Ack SHALL be a change of TIE_EXPSTATE[ACK_BIT] against its registered copy, detected only in ASSERT; toggles in IDLE/HOLD SHALL update the copy and be ignored.
REQ-021 On ack: BInterrupt06 low, pending[irq_id] cleared and rr_ptr = irq_id+1 (wrap at NUM_SRC to 0), all on the same edge.
REQ-022 A new rise on source irq_id in the ack cycle SHALL leave pending[irq_id] set (set wins).
REQ-023 cfg_we SHALL update mask next edge; masking the serviced source in ASSERT SHALL NOT retract BInterrupt06.
REQ-024 Masked pending bits SHALL be retained and served once unmasked.
REQ-025 irq_id SHALL hold its value outside ASSERT.

Reset
REQ-026 BReset SHALL force IDLE, BInterrupt06=0, irq_id=0, pending=0, mask=all-ones, rr_ptr=0, timeout_flag=0, src_q=0, ack copy=0.
REQ-027 Reset mid-ASSERT SHALL drop BInterrupt06 the same instant, losing the in-flight request.

Configuration
REQ-028 With MMIO_IRQ_TIMEOUT_EN defined, a counter SHALL run in ASSERT; at TIMEOUT_CYCLES without ack: BInterrupt06 low, go HOLD, pending kept, rr_ptr=irq_id+1, timeout_flag set until reset.
REQ-029 Without MMIO_IRQ_TIMEOUT_EN, ASSERT SHALL wait indefinitely, no counter SHALL exist, timeout_flag SHALL be tied 0.

Structure
REQ-030 Package mmio_irq_pkg SHALL hold the FSM state type, width constants and parameter defaults.
REQ-031 Round-robin selection SHALL be in sub-module mmio_irq_rr_arb (inputs req, ptr; outputs grant index, valid).

Verification
REQ-032 Reset, pulse src_irq[3] -> BInterrupt06=1 two cycles after rise, irq_id=3; toggle ACK bit -> low next cycle, pending[3]=0.
REQ-033 src_irq[1],[5] rise same cycle -> serve 1, ack, 4-cycle gap, serve 5, ack; then rise 1,5 again -> serve 1 (ptr wrapped past 5).
REQ-034 mask=0xF7, rise 3 -> no interrupt, pending[3]=1; write mask=0xFF -> serve 3.
REQ-035 Rise 2 in same cycle as ack of 2 -> pending[2] stays 1, reasserted after HOLDOFF with irq_id=2.
REQ-036 MMIO_IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> BInterrupt06 low after 16 cycles, timeout_flag=1, pending retained; undefined -> stays high 2000 cycles.
REQ-037 BReset pulse during ASSERT -> BInterrupt06=0 asynchronously, pending=0, mask=0xFF.

Source files
------------

// File: rtl/mmio_irq_pkg.sv
// Shared types, widths and parameter defaults for the MMIO interrupt scheduler.
package mmio_irq_pkg;

  localparam int unsigned IdW            = 5;
  localparam int unsigned HoldCntW       = 4;
  localparam int unsigned NumSrcDefault  = 8;
  localparam int unsigned AckBitDefault  = 0;
  localparam int unsigned HoldoffDefault = 4;
  localparam int unsigned TimeoutDefault = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StHold
  } state_e;

  // HOLD plus the IDLE pass-through together span the holdoff gap (minimum two cycles).
  function automatic logic [HoldCntW-1:0] hold_load(input int unsigned holdoff);
    return (holdoff >= 2) ? HoldCntW'(holdoff - 2) : '0;
  endfunction

endpackage

// File: rtl/mmio_irq_rr_arb.sv
// Round-robin selector: first set request at or after ptr, wrapping at N.
module mmio_irq_rr_arb
  import mmio_irq_pkg::*;
#(
  parameter int unsigned N = NumSrcDefault
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [IdW-1:0] grant,
  output logic           valid
);

  logic [31:0]  req_w;
  logic [IdW:0] idx;

  assign req_w = 32'(req);

  // Walk offsets from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IdW + 1)'(k);
      if (idx >= (IdW + 1)'(N)) idx = idx - (IdW + 1)'(N);
      if (req_w[idx[IdW-1:0]]) begin
        grant = idx[IdW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_irq_sched.sv
// MMIO interrupt scheduler: edge-captured pending bits, round-robin service, toggle ack.
// Optional ack watchdog is built when MMIO_IRQ_TIMEOUT_EN is defined.
module mmio_irq_sched
  import mmio_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC        = NumSrcDefault,
  parameter int unsigned ACK_BIT        = AckBitDefault,
  parameter int unsigned HOLDOFF        = HoldoffDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic               CLK,
  input  logic               BReset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  input  logic [31:0]        TIE_EXPSTATE,
  output logic               BInterrupt06,
  output logic [IdW-1:0]     irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic               timeout_flag
);

  localparam logic [HoldCntW-1:0] HoldLoad = hold_load(HOLDOFF);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   src_q, pending_q, pending_d, mask_q, mask_d, rise, clr;
  logic [IdW-1:0]       irq_id_q, irq_id_d, rr_ptr_q, rr_ptr_d, next_ptr, grant;
  logic [HoldCntW-1:0]  hold_cnt_q, hold_cnt_d;
  logic                 ack_q, ack_bit, ack, grant_valid, timeout_hit;
  logic                 unused_exp;

  assign unused_exp = ^TIE_EXPSTATE;
  assign ack_bit    = TIE_EXPSTATE[ACK_BIT];
  assign rise       = src_irq & ~src_q;
  assign ack        = (state_q == StAssert) && (ack_bit != ack_q);
  assign next_ptr   = (irq_id_q == IdW'(NUM_SRC - 1)) ? '0 : irq_id_q + IdW'(1);

  mmio_irq_rr_arb #(
    .N(NUM_SRC)
  ) u_arb (
    .req  (pending_q & mask_q),
    .ptr  (rr_ptr_q),
    .grant(grant),
    .valid(grant_valid)
  );

`ifdef MMIO_IRQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_flag_q, to_flag_d;

  always_comb begin
    timeout_hit = (state_q == StAssert) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    to_cnt_d    = (state_q == StAssert) ? to_cnt_q + ToW'(1) : '0;
    to_flag_d   = to_flag_q | (timeout_hit & ~ack);
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign timeout_flag = to_flag_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    clr        = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d  = StAssert;
          irq_id_d = grant;
        end
      end
      StAssert: begin
        // Ack beats a coincident timeout; only an ack retires the pending bit.
        if (ack || timeout_hit) begin
          state_d    = StHold;
          rr_ptr_d   = next_ptr;
          hold_cnt_d = HoldLoad;
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            clr[i] = ack && (irq_id_q == IdW'(i));
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) state_d = StIdle;
        else                  hold_cnt_d = hold_cnt_q - HoldCntW'(1);
      end
      default: state_d = StIdle;
    endcase
    // A rise in the ack cycle re-arms the bit being cleared.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = cfg_we ? cfg_wdata : mask_q;
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      state_q    <= StIdle;
      src_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      irq_id_q   <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_irq;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_id_q   <= irq_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_bit;
    end
  end

  assign BInterrupt06 = (state_q == StAssert);
  assign irq_id       = irq_id_q;
  assign pending      = pending_q;
  assign mask         = mask_q;

endmodule

// File: tb/tb_mmio_irq_sched.sv
// Directed bench for mmio_irq_sched with a transaction-level reference model checked every cycle.
module tb_mmio_irq_sched;

  localparam int unsigned N       = 8;
  localparam int unsigned ACK_BIT = 0;
  localparam int unsigned HOLDOFF = 4;
`ifdef MMIO_IRQ_TIMEOUT_EN
  localparam int unsigned TO      = 16;
  localparam bit          TO_EN   = 1'b1;
`else
  localparam int unsigned TO      = 1024;
  localparam bit          TO_EN   = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          BReset;
  logic [N-1:0]  src_irq;
  logic          cfg_we;
  logic [N-1:0]  cfg_wdata;
  logic [31:0]   TIE_EXPSTATE;
  logic          BInterrupt06;
  logic [4:0]    irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;
  logic          timeout_flag;

  int n_checks = 0;
  int n_errors = 0;

  mmio_irq_sched #(
    .NUM_SRC       (N),
    .ACK_BIT       (ACK_BIT),
    .HOLDOFF       (HOLDOFF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK         (CLK),
    .BReset      (BReset),
    .src_irq     (src_irq),
    .cfg_we      (cfg_we),
    .cfg_wdata   (cfg_wdata),
    .TIE_EXPSTATE(TIE_EXPSTATE),
    .BInterrupt06(BInterrupt06),
    .irq_id      (irq_id),
    .pending     (pending),
    .mask        (mask),
    .timeout_flag(timeout_flag)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: service slots, holdoff windows and a watchdog, in plain arithmetic.
  logic [N-1:0] m_pend, m_mask, m_src, m_rise, m_clr, m_req;
  bit           m_serving, m_flag, m_ackprev, m_ackev, m_found;
  int           m_id, m_ptr, m_cyc, m_start, m_earliest, m_win;

  always @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      m_pend = '0; m_mask = '1; m_src = '0; m_serving = 0; m_flag = 0; m_ackprev = 0;
      m_id = 0; m_ptr = 0; m_earliest = 0; m_start = 0;
    end else begin
      m_cyc++;
      m_rise  = src_irq & ~m_src;
      m_clr   = '0;
      m_ackev = m_serving && (TIE_EXPSTATE[ACK_BIT] != m_ackprev);
      if (m_serving) begin
        if (m_ackev) begin
          m_clr[m_id] = 1'b1;
          m_serving = 0; m_ptr = (m_id + 1) % N; m_earliest = m_cyc + HOLDOFF;
        end else if (TO_EN && (m_cyc - m_start) >= TO) begin
          m_flag = 1; m_serving = 0; m_ptr = (m_id + 1) % N; m_earliest = m_cyc + HOLDOFF;
        end
      end else if (m_cyc >= m_earliest) begin
        m_req = m_pend & m_mask;
        m_found = 0; m_win = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && m_req[(m_ptr + k) % N]) begin
            m_found = 1; m_win = (m_ptr + k) % N;
          end
        end
        if (m_found) begin
          m_serving = 1; m_id = m_win; m_start = m_cyc;
        end
      end
      m_pend    = (m_pend & ~m_clr) | m_rise;
      m_mask    = cfg_we ? cfg_wdata : m_mask;
      m_src     = src_irq;
      m_ackprev = TIE_EXPSTATE[ACK_BIT];
    end
  end

  always @(negedge CLK) begin
    if (!BReset) begin
      check("m_irq",     32'(BInterrupt06), 32'(m_serving));
      check("m_id",      32'(irq_id),       32'(m_id));
      check("m_pending", 32'(pending),      32'(m_pend));
      check("m_mask",    32'(mask),         32'(m_mask));
      check("m_flag",    32'(timeout_flag), 32'(m_flag));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic toggle_ack();
    TIE_EXPSTATE[ACK_BIT] = ~TIE_EXPSTATE[ACK_BIT];
  endtask

  task automatic wait_irq(input logic lvl, input int max_cyc, input string name);
    bit ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge CLK);
      if (BInterrupt06 == lvl) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: BInterrupt06 never reached %0b within %0d cycles", name, lvl, max_cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    BReset = 1'b1;
    step(1);
    BReset = 1'b0;
  endtask

  initial begin
    BReset = 1'b1; src_irq = '0; cfg_we = 1'b0; cfg_wdata = '0;
    TIE_EXPSTATE = 32'hA5A5_0000;
    step(2);
    check("rst_irq",  32'(BInterrupt06), 32'h0);
    check("rst_id",   32'(irq_id),       32'h0);
    check("rst_pend", 32'(pending),      32'h00);
    check("rst_mask", 32'(mask),         32'hFF);
    check("rst_flag", 32'(timeout_flag), 32'h0);
    BReset = 1'b0;

    // Single source: two-cycle latency, toggle ack, non-ack bits ignored.
    step(1); src_irq[3] = 1'b1;
    step(1); check("t1_pend", 32'(pending), 32'h08); check("t1_early", 32'(BInterrupt06), 32'h0);
    src_irq[3] = 1'b0;
    step(1); check("t1_irq", 32'(BInterrupt06), 32'h1); check("t1_id", 32'(irq_id), 32'h3);
    TIE_EXPSTATE[4] = ~TIE_EXPSTATE[4];
    step(1); check("t1_noack", 32'(BInterrupt06), 32'h1);
    toggle_ack();
    step(1); check("t1_ack", 32'(BInterrupt06), 32'h0); check("t1_clr", 32'(pending), 32'h00);
    check("t1_idhold", 32'(irq_id), 32'h3);
    step(8);

    // Round-robin 1 then 5, exact holdoff gap, then pointer wrap back to 1.
    do_reset();
    step(1); src_irq = 8'h22;
    step(1); src_irq = '0;
    step(1); check("t2_id1", 32'(irq_id), 32'h1); check("t2_irq1", 32'(BInterrupt06), 32'h1);
    toggle_ack();
    step(1); check("t2_low", 32'(BInterrupt06), 32'h0);
    step(3); check("t2_gap", 32'(BInterrupt06), 32'h0);
    step(1); check("t2_irq5", 32'(BInterrupt06), 32'h1); check("t2_id5", 32'(irq_id), 32'h5);
    toggle_ack();
    step(6); src_irq = 8'h22;
    step(1); src_irq = '0;
    step(1); check("t2_wrap", 32'(irq_id), 32'h1); check("t2_irqw", 32'(BInterrupt06), 32'h1);
    toggle_ack(); step(1);
    wait_irq(1'b1, 10, "t2_serve5b");
    toggle_ack(); step(8);

    // Masked source is retained and served once unmasked.
    cfg_we = 1'b1; cfg_wdata = 8'hF7;
    step(1); cfg_we = 1'b0; src_irq[3] = 1'b1;
    step(1); src_irq[3] = 1'b0;
    step(3); check("t3_quiet", 32'(BInterrupt06), 32'h0); check("t3_pend", 32'(pending), 32'h08);
    check("t3_mask", 32'(mask), 32'hF7);
    cfg_we = 1'b1; cfg_wdata = 8'hFF;
    step(1); cfg_we = 1'b0;
    step(1); check("t3_irq", 32'(BInterrupt06), 32'h1); check("t3_id", 32'(irq_id), 32'h3);
    toggle_ack(); step(6);

    // Rise during ack of the same source keeps it pending; masking in ASSERT does not retract.
    src_irq[2] = 1'b1;
    step(1); src_irq[2] = 1'b0;
    step(1); check("t4_id", 32'(irq_id), 32'h2);
    toggle_ack(); src_irq[2] = 1'b1;
    step(1); src_irq[2] = 1'b0;
    check("t4_low", 32'(BInterrupt06), 32'h0); check("t4_pend", 32'(pending), 32'h04);
    step(3); check("t4_gap", 32'(BInterrupt06), 32'h0);
    step(1); check("t4_re", 32'(BInterrupt06), 32'h1); check("t4_reid", 32'(irq_id), 32'h2);
    cfg_we = 1'b1; cfg_wdata = 8'hFB;
    step(1); cfg_we = 1'b0;
    step(1); check("t4_masked", 32'(BInterrupt06), 32'h1);
    toggle_ack(); cfg_we = 1'b1; cfg_wdata = 8'hFF;
    step(1); cfg_we = 1'b0;
    step(6);

    // Watchdog, or indefinite wait when it is not built.
    src_irq[0] = 1'b1;
    step(1); src_irq[0] = 1'b0;
    step(1); check("t5_irq", 32'(BInterrupt06), 32'h1); check("t5_id", 32'(irq_id), 32'h0);
`ifdef MMIO_IRQ_TIMEOUT_EN
    step(TO - 1); check("t5_last", 32'(BInterrupt06), 32'h1);
    step(1); check("t5_to", 32'(BInterrupt06), 32'h0);
    check("t5_flag", 32'(timeout_flag), 32'h1); check("t5_kept", 32'(pending), 32'h01);
    wait_irq(1'b1, 20, "t5_reassert");
`else
    step(2000); check("t5_stay", 32'(BInterrupt06), 32'h1);
    check("t5_flag", 32'(timeout_flag), 32'h0);
`endif

    // Asynchronous reset mid-ASSERT.
    @(posedge CLK); #2 BReset = 1'b1;
    #1;
    check("t6_irq",  32'(BInterrupt06), 32'h0);
    check("t6_pend", 32'(pending),      32'h00);
    check("t6_mask", 32'(mask),         32'hFF);
    check("t6_flag", 32'(timeout_flag), 32'h0);
    @(negedge CLK); BReset = 1'b0;
    step(1); src_irq[6] = 1'b1;
    step(1); src_irq[6] = 1'b0;
    step(1); check("t6_post", 32'(irq_id), 32'h6); check("t6_posti", 32'(BInterrupt06), 32'h1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
